dct_1d_sequencer: RTL and testbench
===================================

Name: dct_1d_sequencer

Overview:
- Sequences one 8-point 1-D DCT on the shared 8-way multiply-accumulate unit (8 Q16.16 data × 8 coefficients → 1 Q16.16 sum, registered).
- Accepts an 8-sample vector, issues 8 MAC operations (coefficient rows k=0..7) against the held vector, and collects the 8 results into an output vector with a valid/ready handshake.
- Sits between the block-row buffer and the transpose/quantise stage; the coefficient table is external and combinational, indexed by this block.

Parameters:
- DATA_WIDTH, 32, sample/coefficient/result width (Q16.16).
- DATA_DEPTH, 8, points per transform; the rest of this spec fixes it at 8.
- MAC_LAT, 1, clock cycles from MAC operand presentation to valid mac_result; legal range 1..4.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  input vector valid
- in_ready  out  1  block can accept a vector
- in_data  in  DATA_WIDTH*DATA_DEPTH  samples; element i at [i*DATA_WIDTH +: DATA_WIDTH]
- coeff_row_idx  out  3  coefficient row index driven to external table
- coeff_row  in  DATA_WIDTH*DATA_DEPTH  coefficient row for coeff_row_idx, combinational, same cycle
- mac_data  out  DATA_WIDTH*DATA_DEPTH  MAC data operand (held vector)
- mac_coeff  out  DATA_WIDTH*DATA_DEPTH  MAC coefficient operand (pass-through of coeff_row)
- mac_issue  out  1  high in cycles where the MAC operands are meaningful
- mac_result  in  DATA_WIDTH  MAC output
- out_valid  out  1  result vector valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_WIDTH*DATA_DEPTH  results; coefficient k at [k*DATA_WIDTH +: DATA_WIDTH]
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, DRAIN, OUTPUT. Reset → IDLE, all counters 0, out_data 0, held vector 0, valid pipe 0.
- Reset values: in_ready=1 (IDLE), out_valid=0, mac_issue=0, coeff_row_idx=0, busy=0, mac_data=0.
- in_ready = (state==IDLE), combinational. No acceptance in any other state.
- IDLE: on in_valid&&in_ready at edge E0, register in_data into the held vector, issue counter k=0, capture counter c=0 → ISSUE.
- ISSUE: mac_issue=1, coeff_row_idx=k, mac_coeff=coeff_row, mac_data=held vector. k increments each cycle. After the cycle with k=7 (edge E8) → DRAIN.
- Valid pipe: mac_issue is delayed through a MAC_LAT-deep shift register. When the pipe output is 1, mac_result is written into out_data slot c at the next edge and c increments. Issue k is captured at edge E(k+1+MAC_LAT).
- DRAIN: mac_issue=0, coeff_row_idx holds 7. Leave DRAIN at the edge capturing c=7.
- The final capture occurs at E(8+MAC_LAT). State → OUTPUT at that edge. out_valid is high from then on (MAC_LAT=1: 9 cycles after accept).
- If MAC_LAT=1, the final capture and the ISSUE→DRAIN exit are one edge apart. DRAIN lasts MAC_LAT cycles.
- OUTPUT: out_valid=1; out_data stable until handshake. On out_valid&&out_ready → IDLE. out_data retains its value after leaving OUTPUT.
- Back-to-back throughput with out_ready tied high: one vector per 10+MAC_LAT cycles (11 for MAC_LAT=1).
- mac_data and mac_coeff are don't-care when mac_issue=0. mac_data still holds the last vector.
- Arithmetic: none inside this block. Results are stored verbatim; no truncation or saturation.
- Reset mid-operation: immediate return to IDLE. The partial vector is discarded; out_valid and mac_issue drop asynchronously. Late mac_result values after reset are ignored because the valid pipe is cleared.
- in_valid during ISSUE/DRAIN/OUTPUT is ignored and in_data is not sampled. Upstream must hold the vector until in_ready.

Test Plan:
- Use a behavioural MAC model (sum of data×coeff>>16, MAC_LAT registers) and a unit-vector coefficient table (row k = 0x00010000 at element k, else 0). Input in_data element i = i·0x00010000. Required: out_data slot k = k·0x00010000, out_valid rises exactly 9 cycles after the accept edge, and mac_issue is high for exactly 8 cycles with coeff_row_idx 0..7.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_valid and out_data stable, in_ready=0 and busy=1 throughout, then IDLE one cycle after the handshake.
- Back-to-back streaming of 4 vectors with in_valid and out_ready held high. Required: accepts spaced 11 cycles apart, 4 outputs each matching the model, no dropped or duplicated vectors.
- MAC_LAT=3 build with the same stimulus. Required: out_valid 11 cycles after accept and slot ordering unchanged.
- Drop reset_n during ISSUE at k=4. Required: in_ready=1, out_valid=0, mac_issue=0 immediately. A new vector afterwards completes correctly with no stale slots written.
- in_valid toggled during ISSUE with a different vector. Required: it is ignored, the output reflects only the accepted vector, and the second vector is accepted only after returning to IDLE.

Source files
------------

// File: rtl/dct_1d_sequencer.sv
// dct_1d_sequencer
// Sequences one 8-point 1-D DCT on the shared 8-way MAC unit. An accepted
// 8-sample vector is held while coefficient rows k=0..7 are issued one per
// cycle. MAC results return MAC_LAT cycles later and are collected, in issue
// order, into the output vector, which is offered with a valid/ready handshake.
//
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   in_valid/in_ready  input vector handshake (ready only in IDLE)
//   in_data            8 samples, element i at [i*DATA_WIDTH +: DATA_WIDTH]
//   coeff_row_idx      row index to the external combinational coefficient table
//   coeff_row          coefficient row returned in the same cycle
//   mac_data/mac_coeff MAC operands (held vector / coeff_row pass-through)
//   mac_issue          operands meaningful this cycle
//   mac_result         MAC output, valid MAC_LAT cycles after issue
//   out_valid/out_ready result vector handshake
//   out_data           results, row k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy               not in IDLE
module dct_1d_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int DATA_DEPTH = 8,
    parameter int MAC_LAT    = 1
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] in_data,
    output logic [2:0]                       coeff_row_idx,
    input  logic [DATA_WIDTH*DATA_DEPTH-1:0] coeff_row,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] mac_data,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] mac_coeff,
    output logic                             mac_issue,
    input  logic [DATA_WIDTH-1:0]            mac_result,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [DATA_WIDTH*DATA_DEPTH-1:0] out_data,
    output logic                             busy
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;
    localparam logic [2:0] LAST     = 3'd7;

    logic [1:0]                           state_q, state_d;
    logic [2:0]                           k_q, k_d;
    logic [2:0]                           c_q, c_d;
    logic [DATA_WIDTH*DATA_DEPTH-1:0]     held_q, held_d;
    logic [DATA_DEPTH-1:0][DATA_WIDTH-1:0] res_q, res_d;
    logic [MAC_LAT-1:0]                   vld_pipe_q, vld_pipe_d;
    logic                                 cap;

    // The issue strobe delayed by MAC_LAT marks the cycle mac_result is valid.
    assign cap = vld_pipe_q[MAC_LAT-1];

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        c_d     = c_q;
        held_d  = held_q;
        res_d   = res_q;

        vld_pipe_d[0] = (state_q == S_ISSUE);
        for (int i = 1; i < MAC_LAT; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

        if (cap) begin
            res_d[c_q] = mac_result;
            c_d        = c_q + 3'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    held_d  = in_data;
                    k_d     = 3'd0;
                    c_d     = 3'd0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // k stops at 7 so coeff_row_idx holds the last row in DRAIN.
                if (k_q == LAST) state_d = S_DRAIN;
                else             k_d     = k_q + 3'd1;
            end
            S_DRAIN: begin
                if (cap && c_q == LAST) state_d = S_OUTPUT;
            end
            default: begin
                if (out_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            k_q        <= '0;
            c_q        <= '0;
            held_q     <= '0;
            res_q      <= '0;
            vld_pipe_q <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            c_q        <= c_d;
            held_q     <= held_d;
            res_q      <= res_d;
            vld_pipe_q <= vld_pipe_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign mac_issue     = (state_q == S_ISSUE);
    assign out_valid     = (state_q == S_OUTPUT);
    assign busy          = (state_q != S_IDLE);
    assign coeff_row_idx = k_q;
    assign mac_data      = held_q;
    assign mac_coeff     = coeff_row;
    assign out_data      = res_q;

endmodule

// File: tb/tb_dct_1d_sequencer.sv
module tb_dct_1d_sequencer;

    localparam int VW = 256;

    logic clk = 1'b0;
    logic reset_n;
    logic in_valid;
    logic out_ready;
    logic [VW-1:0] in_data;
    int cur_mode;
    logic [VW-1:0] cur_exp;

    logic in_ready, mac_issue, out_valid, busy;
    logic [2:0] coeff_row_idx;
    logic [VW-1:0] coeff_row, mac_data, mac_coeff, out_data;
    logic [31:0] mac_result;

    logic in_ready_3, mac_issue_3, out_valid_3, busy_3;
    logic [2:0] coeff_row_idx_3;
    logic [VW-1:0] coeff_row_3, mac_data_3, mac_coeff_3, out_data_3;
    logic [31:0] mac_result_3, m3a, m3b;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int cyc = 0;
    logic [VW-1:0] sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: unit row k at element k; 1: element 7-k; 2: value 2.0 at element k
    function automatic logic [VW-1:0] row_of(input int mode, input logic [2:0] idx);
        logic [VW-1:0] r;
        int pos;
        r = '0;
        pos = (mode == 1) ? 7 - int'(idx) : int'(idx);
        r[pos*32 +: 32] = (mode == 2) ? 32'h0002_0000 : 32'h0001_0000;
        return r;
    endfunction

    function automatic logic [31:0] dot(input logic [VW-1:0] d, input logic [VW-1:0] c);
        longint acc;
        acc = 0;
        for (int i = 0; i < 8; i++)
            acc += longint'($signed(d[i*32 +: 32])) * longint'($signed(c[i*32 +: 32]));
        acc = acc >>> 16;
        return acc[31:0];
    endfunction

    assign coeff_row   = row_of(cur_mode, coeff_row_idx);
    assign coeff_row_3 = row_of(cur_mode, coeff_row_idx_3);

    always @(posedge clk) begin
        mac_result   <= dot(mac_data, mac_coeff);
        m3a          <= dot(mac_data_3, mac_coeff_3);
        m3b          <= m3a;
        mac_result_3 <= m3b;
    end

    dct_1d_sequencer #(.DATA_WIDTH(32), .DATA_DEPTH(8), .MAC_LAT(1)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .coeff_row_idx(coeff_row_idx), .coeff_row(coeff_row),
        .mac_data(mac_data), .mac_coeff(mac_coeff), .mac_issue(mac_issue),
        .mac_result(mac_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy)
    );

    dct_1d_sequencer #(.DATA_WIDTH(32), .DATA_DEPTH(8), .MAC_LAT(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_3),
        .in_data(in_data), .coeff_row_idx(coeff_row_idx_3), .coeff_row(coeff_row_3),
        .mac_data(mac_data_3), .mac_coeff(mac_coeff_3), .mac_issue(mac_issue_3),
        .mac_result(mac_result_3), .out_valid(out_valid_3), .out_ready(out_ready),
        .out_data(out_data_3), .busy(busy_3)
    );

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard on the MAC_LAT=1 instance: push at accept, compare at output.
    always @(negedge clk) begin
        if (reset_n) begin
            if (in_valid && in_ready) sb.push_back(cur_exp);
            if (out_valid && out_ready) begin
                pops++;
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_underflow: output with no accepted vector, got %h", out_data);
                end else begin
                    chk("sb_out", out_data, sb.pop_front());
                end
            end
        end
    end

    typedef struct {
        int           mode;
        logic [VW-1:0] din;
        logic [VW-1:0] exp;
    } vec_t;
    vec_t tbl[6];

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
    endtask

    // Single vector through both instances, with latency and issue-sequence checks.
    task automatic run_one(input logic [VW-1:0] din, input logic [VW-1:0] exp, input int mode);
        int lat1, lat3, nis;
        bit seq_ok;
        logic [31:0] nis_w;
        lat1 = -1; lat3 = -1; nis = 0; seq_ok = 1'b1;
        cur_mode = mode; cur_exp = exp; in_data = din; in_valid = 1'b1; out_ready = 1'b1;
        chk("ready_before", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (mac_issue) begin
                nis_w = nis;
                if (coeff_row_idx !== nis_w[2:0] || mac_data !== din) seq_ok = 1'b0;
                nis++;
            end
            if (lat1 < 0 && out_valid) lat1 = n;
            if (lat3 < 0 && out_valid_3) begin
                lat3 = n;
                chk("dut3_data", out_data_3, exp);
            end
            if (lat1 >= 0 && lat3 >= 0 && in_ready && in_ready_3) break;
            @(posedge clk); #1;
        end
        chk("latency_lat1", lat1, 9);
        chk("latency_lat3", lat3, 11);
        chk("issue_count", nis, 8);
        chk("issue_seq", seq_ok, 1'b1);
    endtask

    initial begin
        logic [VW-1:0] saved, vb;
        logic [VW-1:0] sv[4];
        int acc[4];
        int t, acc_a, acc_b, p0;
        bit st_ok;

        for (int i = 0; i < 6; i++) begin
            tbl[i].mode = i % 3;
            for (int e = 0; e < 8; e++)
                tbl[i].din[e*32 +: 32] = (i == 0) ? e * 32'h0001_0000 : $urandom;
            for (int k = 0; k < 8; k++) begin
                case (tbl[i].mode)
                    0: tbl[i].exp[k*32 +: 32] = tbl[i].din[k*32 +: 32];
                    1: tbl[i].exp[k*32 +: 32] = tbl[i].din[(7-k)*32 +: 32];
                    default: tbl[i].exp[k*32 +: 32] = tbl[i].din[k*32 +: 32] << 1;
                endcase
            end
        end

        reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        cur_mode = 0; cur_exp = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_mac_issue", mac_issue, 1'b0);
        chk("rst_idx", coeff_row_idx, 3'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mac_data", mac_data, '0);
        chk("rst_out_data", out_data, '0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) run_one(tbl[i].din, tbl[i].exp, tbl[i].mode);

        // Backpressure: hold the result for 5 cycles.
        cur_mode = 0; cur_exp = tbl[0].exp; in_data = tbl[0].din;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 40) begin @(posedge clk); #1; t++; end
        chk("bp_valid", out_valid, 1'b1);
        saved = out_data;
        st_ok = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            if (!out_valid || out_data !== saved || in_ready || !busy) st_ok = 1'b0;
        end
        chk("bp_stable", st_ok, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle", in_ready, 1'b1);
        chk("bp_busy", busy, 1'b0);
        chk("bp_retain", out_data, saved);
        do_reset();

        // Back-to-back streaming of 4 vectors.
        cur_mode = 0; out_ready = 1'b1; p0 = pops;
        for (int j = 0; j < 4; j++) begin
            for (int e = 0; e < 8; e++) sv[j][e*32 +: 32] = $urandom;
            in_data = sv[j]; cur_exp = sv[j]; in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
            @(posedge clk); #1;
            acc[j] = cyc;
        end
        in_valid = 1'b0;
        for (int j = 1; j < 4; j++) chk("stream_gap", acc[j] - acc[j-1], 11);
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 100) begin @(posedge clk); #1; t++; end
        chk("stream_outs", pops - p0, 4);
        chk("stream_sb_empty", sb.size(), 0);
        do_reset();

        // Reset during ISSUE at k=4, then a clean vector.
        cur_mode = 1; cur_exp = tbl[1].exp; in_data = tbl[1].din; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("rst_mid_k", coeff_row_idx, 3'd4);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_in_ready", in_ready, 1'b1);
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_mac_issue", mac_issue, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        sb.delete();
        chk("rst_mid_out_data", out_data, '0);
        run_one(tbl[2].din, tbl[2].exp, tbl[2].mode);

        // A second vector offered during ISSUE must wait for IDLE.
        do_reset();
        cur_mode = 0; cur_exp = tbl[3].exp; in_data = tbl[3].din; in_valid = 1'b1;
        @(posedge clk); #1;
        acc_a = cyc;
        for (int e = 0; e < 8; e++) vb[e*32 +: 32] = $urandom;
        in_data = vb; cur_exp = vb;
        t = 0;
        while (!in_ready && t < 50) begin @(posedge clk); #1; t++; end
        @(posedge clk); #1;
        acc_b = cyc;
        in_valid = 1'b0;
        chk("ignore_gap", acc_b - acc_a, 11);
        t = 0;
        while ((sb.size() != 0 || !in_ready) && t < 100) begin @(posedge clk); #1; t++; end
        chk("ignore_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
